// File: rtl/seq_hit_logger.sv
`default_nettype none
// ============================================================================
// Module  : seq_hit_logger
// Brief   : Timestamps rising edges of a detector output and buffers them in a
//           first-word-fall-through FIFO, with saturating hit/drop counters.
// Revision: 1.0 - initial release
// ============================================================================
module seq_hit_logger #(
    parameter int TS_W  = 16,
    parameter int DEPTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     en,
    input  logic                     clr,
    input  logic                     det_in,
    output logic                     out_valid,
    output logic [TS_W-1:0]          out_ts,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   level,
    output logic [CNT_W-1:0]         hit_count,
    output logic [CNT_W-1:0]         drop_count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0]    c_full    = LW'(DEPTH);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [TS_W-1:0]  r_mem [DEPTH];
    logic [TS_W-1:0]  r_ts;
    logic             r_det_prev;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [LW-1:0]    r_level;
    logic [CNT_W-1:0] r_hit;
    logic [CNT_W-1:0] r_drop;
    logic             r_overflow;

    logic w_event;
    logic w_pop;
    logic w_full;
    logic w_push;
    logic w_drop;
    logic w_run;

    assign w_run   = reset && !clr;
    assign w_event = det_in && !r_det_prev && en;
    assign w_pop   = out_valid && out_ready;
    assign w_full  = (r_level == c_full);
    // A pop on the same edge frees the slot, so a full FIFO still accepts.
    assign w_push  = w_event && (!w_full || w_pop);
    assign w_drop  = w_event && w_full && !w_pop;

    assign out_valid  = (r_level != '0);
    assign out_ts     = r_mem[r_rd_ptr];
    assign level      = r_level;
    assign hit_count  = r_hit;
    assign drop_count = r_drop;
    assign overflow   = r_overflow;

    always_ff @(posedge clk) begin
        if (w_run && w_push) begin
            r_mem[r_wr_ptr] <= r_ts;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_ts       <= '0;
            r_det_prev <= 1'b0;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_level    <= '0;
            r_hit      <= '0;
            r_drop     <= '0;
            r_overflow <= 1'b0;
        end else if (clr) begin
            r_ts       <= '0;
            r_det_prev <= det_in;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_level    <= '0;
            r_hit      <= '0;
            r_drop     <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_ts       <= r_ts + 1'b1;
            r_det_prev <= det_in;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
            if (w_event && (r_hit != c_cnt_max)) begin
                r_hit <= r_hit + 1'b1;
            end
            if (w_drop) begin
                if (r_drop != c_cnt_max) begin
                    r_drop <= r_drop + 1'b1;
                end
                r_overflow <= 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/seq_hit_logger.md
Name: seq_hit_logger

Overview:
- Downstream consumer of the serial sequence detector's single-bit Moore output `y`, which drives `det_in` here.
- Turns each detection into a timestamped event and buffers events in a small first-word-fall-through FIFO.
- Events are read out over a valid/ready handshake.
- Keeps saturating hit and drop counters plus a sticky overflow flag for status readback.

Parameters:
- TS_W, 16, width of the free-running timestamp counter and of each FIFO entry.
- DEPTH, 8, FIFO entry count; power of two, ≥2.
- CNT_W, 8, width of the hit and drop counters; both saturate at all-ones.

Ports:
- clk  input  1  system clock; all logic updates on its rising edge.
- reset  input  1  synchronous, active-low reset; asserted when 0, sampled on the rising clk edge.
- en  input  1  event capture enable; when 0, edges on det_in are ignored.
- clr  input  1  synchronous soft clear of timestamp, FIFO, counters and flag.
- det_in  input  1  detector output (y); a detection is a 0→1 transition.
- out_valid  output  1  FIFO non-empty; out_ts holds the oldest entry.
- out_ts  output  TS_W  timestamp of the oldest buffered event.
- out_ready  input  1  consumer accepts out_ts when out_valid && out_ready at a clk edge.
- level  output  $clog2(DEPTH)+1  number of FIFO entries held, 0..DEPTH.
- hit_count  output  CNT_W  detections seen while en=1, including dropped ones; saturating.
- drop_count  output  CNT_W  detections lost because the FIFO was full; saturating.
- overflow  output  1  sticky; set on the first drop.

Behaviour:
- Reset (reset=0 at edge): ts=0, det_prev=0, FIFO empty, level=0, out_valid=0, hit_count=0, drop_count=0, overflow=0.
  - out_ts is don't-care while out_valid=0.
  - Reset has priority over everything, including mid-burst and mid-handshake.
- Timestamp:
  - ts increments by 1 every non-reset, non-clr edge and wraps from 2^TS_W-1 to 0.
  - It runs regardless of en.
- Edge detect:
  - det_prev <= det_in every edge.
  - event = det_in & ~det_prev & en, evaluated on the values present before the edge.
  - A level held high counts once.
  - det_prev is 0 after reset, so det_in=1 on the first active edge is an event.
- Push: on an event edge, the value of ts before that edge's increment is written.
  - out_valid rises one cycle after the capturing edge (1-cycle latency).
- Pop: at an edge with out_valid && out_ready, the head is removed.
  - out_ts shows the next entry, or out_valid falls, after that edge.
- Simultaneous push and pop:
  - Both occur.
  - When full, the pop frees the slot so the push is accepted; level stays unchanged and nothing is dropped.
  - When empty, no pop occurs because out_valid=0; the push succeeds and level becomes 1.
- Full with no pop at an event edge:
  - The entry is discarded.
  - drop_count += 1 (saturating).
  - overflow <= 1, and it stays 1 until reset or clr.
- hit_count += 1 (saturating) on every event, whether it is stored or dropped.
- Saturation: counters at 2^CNT_W-1 hold their value and never wrap.
- clr=1 at an edge:
  - ts=0, FIFO emptied, counters=0, overflow=0, det_prev <= det_in.
  - An event on the same edge is discarded and not counted.
  - A pop on the same edge has no effect beyond the clear.
- State per FIFO: read pointer and write pointer of $clog2(DEPTH) bits each, plus a level counter; pointers wrap modulo DEPTH.
- en=0: no events are generated. det_prev still tracks det_in, so an input already high when en rises does not create an event.
- out_ts and out_valid depend only on FIFO state and have no combinational path from out_ready.

Test Plan:
1. Single event: release reset, det_in=0 for 3 edges, then det_in=1 for 2 edges, out_ready=0 → one entry with out_ts=3, level=1, hit_count=1; the held-high second cycle adds nothing.
2. Drain handshake: push events at ts=3, 7, 11, then hold out_ready=1 → out_ts reads 3, 7, 11 on consecutive cycles; out_valid falls after the third pop; level returns to 0.
3. Overflow (DEPTH=8): 10 isolated pulses with out_ready=0 → level=8, hit_count=10, drop_count=2, overflow=1; the stored timestamps are those of the first 8 pulses.
4. Full plus simultaneous pop and push: with the FIFO full, pulse det_in on an edge with out_ready=1 → level stays 8, drop_count unchanged, new timestamp appears at the tail.
5. Wrap and saturation (TS_W=4, CNT_W=3): event at edge 17 → out_ts=1 (ts wrapped); 9 events → hit_count holds at 7.
6. clr and mid-operation reset: with 3 entries and overflow=1, pulse clr → level=0, counters=0, overflow=0, ts restarts at 0; then drive reset=0 during a burst with out_ready=1 → all outputs at reset values on the next edge, and no entry survives.
